pulse_rate_counter: RTL and testbench
=====================================

// Module: pulse_rate_counter
// PURPOSE
//  Receive side of the random pulse generator: counts rising edges of pulse_in over a
//  programmable gate window and presents each count on a valid/ready output port.
//  Used to measure achieved pulse rate against the generator threshold setting.
//  pulse_in is synchronous to clk; no synchronizer is included.
// PARAMETERS
//  CW  32  count/result width
//  GW  32  gate-length width (window length in clk cycles)
// PORTS
//  clk         in   1   clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  pulse_in    in   1   pulse stream (level, any width in cycles)
//  gate_len    in   GW  window length in cycles; 0 = invalid
//  start       in   1   begin a window (sampled in IDLE only)
//  stop        in   1   abort current window, discard partial count
//  cont        in   1   1 = back-to-back windows until stop
//  count       out  CW  result of last completed window
//  count_sat   out  1   result saturated (accompanies count)
//  out_valid   out  1   count/count_sat valid
//  out_ready   in   1   consumer accepts when out_valid & out_ready
//  overrun     out  1   sticky: unconsumed result overwritten
//  busy        out  1   1 while in COUNT
// BEHAVIOUR
//  Reset: state=IDLE, pulse_d=0, acc=0, timer=0, count=0, count_sat=0, out_valid=0,
//   overrun=0, busy=0. Reset mid-window drops all state and any pending result.
//  Edge detect: edge = pulse_in & ~pulse_d; pulse_d <= pulse_in every cycle, all states.
//   A level already high when the window opens is not counted until it falls and rises.
//  IDLE: start=1 & gate_len!=0 -> COUNT, timer<=gate_len, acc<=0, sat<=0.
//   start with gate_len==0 ignored (stay IDLE). start outside IDLE ignored.
//  COUNT: busy=1. If start is sampled at cycle t0, window = cycles t0+1..t0+N, N=gate_len.
//   Each window cycle: acc += edge (saturating at 2^CW-1; sat<=1 on an attempted wrap);
//   timer decrements.
//   Final cycle (timer==1): count<=acc+edge (saturated), count_sat<=sat|wrap, out_valid<=1.
//   out_valid is therefore visible at t0+N+1.
//   Then: cont=1 & gate_len!=0 -> stay COUNT, reload timer=gate_len, acc=0, sat=0.
//   The next window starts at t0+N+1 with no gap; every cycle belongs to exactly one window.
//   Otherwise -> IDLE.
//  stop=1 in COUNT: -> IDLE next cycle, no result, out_valid/count untouched; stop has
//   priority over window completion in the same cycle. stop in IDLE: no effect.
//  Output handshake: out_valid held with count stable until out_valid&out_ready.
//   Transfer cycle clears out_valid, unless a new result loads in the same cycle; then
//   out_valid stays 1 with the new value and no overrun.
//   New result while out_valid=1 and not transferring: overwrite, overrun<=1.
//   overrun clears only on reset.
//  gate_len/cont are sampled only at window start/reload; mid-window changes have no effect.
// TESTING
//  1 gate_len=10, pulse_in 1-cycle high every 2nd cycle from t0+1 -> count=5, out_valid at t0+11.
//  2 pulse_in high t0-2..t0+6, gate_len=20 -> count=0; new 1-cycle pulse at t0+9 -> count=1.
//  3 CW=4, gate_len=50, 20 edges -> count=15, count_sat=1; next window 3 edges -> count_sat=0.
//  4 cont=1, gate_len=8, out_ready=0 for 3 windows -> overrun=1, count=last window value, busy=1.
//  5 stop at t0+4 of 10-cycle window -> busy=0 at t0+5, no out_valid;
//    start with gate_len=0 -> stays IDLE.
//  6 reset asserted mid-COUNT with out_valid=1 -> all outputs 0 next cycle; a fresh start
//    then counts correctly.

Source files
------------

// File: rtl/pulse_rate_counter.sv
// -----------------------------------------------------------------------------
// pulse_rate_counter
// Counts rising edges of pulse_in over a programmable gate window of gate_len
// clock cycles and presents each completed count on a valid/ready output port.
// Windows may run singly (start) or back-to-back without a gap (cont=1).
// pulse_in is assumed synchronous to clk; no synchronizer is included.
// -----------------------------------------------------------------------------
module pulse_rate_counter #(
  parameter int CW = 32,  // count/result width
  parameter int GW = 32   // gate-length width (window length in clk cycles)
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active-high
  input  logic          pulse_in,
  input  logic [GW-1:0] gate_len,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  output logic [CW-1:0] count,
  output logic          count_sat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CW-1:0] ACC_MAX  = {CW{1'b1}};
  localparam logic [GW-1:0] GATE_ONE = GW'(1);

  state_t        state, state_nx;
  logic          pulse_d;
  logic [GW-1:0] timer, timer_nx;
  logic [CW-1:0] acc, acc_nx;
  logic          sat, sat_nx;

  // Derived per-cycle values.
  logic          pulse_edge;   // rising edge of pulse_in this cycle
  logic          wrap;         // this edge would overflow the accumulator
  logic [CW-1:0] acc_sum;      // accumulator plus this cycle's edge, saturated
  logic          last_cycle;   // final cycle of the current window
  logic          gate_ok;      // gate_len is usable for a new window
  logic          load_result;  // a completed window result loads this cycle
  logic          transfer;     // consumer accepts the held result this cycle

  assign pulse_edge = pulse_in & ~pulse_d;
  assign wrap       = pulse_edge & (acc == ACC_MAX);
  assign acc_sum    = wrap ? acc : acc + CW'(pulse_edge);
  assign last_cycle = (timer == GATE_ONE);
  assign gate_ok    = (gate_len != '0);
  assign transfer   = out_valid & out_ready;
  assign busy       = (state == COUNT);

  // Delayed copy of pulse_in for edge detection; runs in every state so a
  // level already high when a window opens is not mistaken for an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (reset) begin
      pulse_d <= 1'b0;
    end else begin
      pulse_d <= pulse_in;
    end
  end

  // Control state, window timer and accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      acc   <= acc_nx;
      sat   <= sat_nx;
    end
  end

  // Next-state logic: window start, per-cycle accumulation, window
  // completion with optional seamless reload, and abort on stop.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nx    = state;
    timer_nx    = timer;
    acc_nx      = acc;
    sat_nx      = sat;
    load_result = 1'b0;

    unique case (state)
      IDLE: begin
        // A zero-length gate is meaningless; such a start is ignored.
        if (start && gate_ok) begin
          state_nx = COUNT;
          timer_nx = gate_len;
          acc_nx   = '0;
          sat_nx   = 1'b0;
        end
      end

      COUNT: begin
        if (stop) begin
          // Abort wins over completion: the partial count is discarded and
          // the output port keeps whatever it already held.
          state_nx = IDLE;
        end else if (last_cycle) begin
          // This cycle's edge still belongs to the window, so the result
          // is acc_sum rather than acc.
          load_result = 1'b1;
          if (cont && gate_ok) begin
            // Next window starts on the very next cycle, no gap.
            timer_nx = gate_len;
            acc_nx   = '0;
            sat_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          acc_nx   = acc_sum;
          sat_nx   = sat | wrap;
          timer_nx = timer - GATE_ONE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Output port: result register with valid/ready handshake and sticky
  // overrun flag for results overwritten before the consumer took them.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      count_sat <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_result) begin
        count     <= acc_sum;
        count_sat <= sat | wrap;
        // A simultaneous transfer frees the slot, so only an untaken result
        // counts as overwritten.
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_pulse_rate_counter
// Directed self-checking bench. Two instances share all inputs: one at the
// default widths and one with CW=4 to exercise result saturation. Single
// windows come from a table of hand-computed vectors; continuous mode,
// stop, reset and handshake corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pulse_rate_counter;

  localparam int CW  = 32;
  localparam int GW  = 32;
  localparam int CW4 = 4;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic [GW-1:0] gate_len;
  logic          start;
  logic          stop;
  logic          cont;
  logic          out_ready;

  logic [CW-1:0]  count;
  logic           count_sat, out_valid, overrun, busy;
  logic [CW4-1:0] count4;
  logic           count_sat4, out_valid4, overrun4, busy4;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_rate_counter #(.CW(CW), .GW(GW)) u_dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .gate_len(gate_len),
    .start(start), .stop(stop), .cont(cont), .count(count),
    .count_sat(count_sat), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .busy(busy)
  );

  pulse_rate_counter #(.CW(CW4), .GW(GW)) u_dut4 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .gate_len(gate_len),
    .start(start), .stop(stop), .cont(cont), .count(count4),
    .count_sat(count_sat4), .out_valid(out_valid4), .out_ready(out_ready),
    .overrun(overrun4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the stimulus is all fixed-length loops, but never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  // One window vector: pulses 1 cycle wide at window cycles k where
  // (k-1)%period==0, limited to n_edges pulses; expected results for both widths.
  typedef struct {
    int          gate;
    int          period;
    int          n_edges;
    int          exp_count;
    int          exp_count4;
    bit          exp_sat4;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Take the held result and confirm the slot empties.
  task automatic consume(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid clears"}, out_valid, 0);
    check({name, " valid4 clears"}, out_valid4, 0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    pulse_in  = 1'b0;
    cont      = 1'b0;
    out_ready = 1'b0;
    gate_len  = GW'(v.gate);
    start     = 1'b1;
    tick();                         // edge t0 samples start
    start    = 1'b0;
    gate_len = GW'(3);              // mid-window change must be ignored
    check({nm, " busy"}, busy, 1);
    for (int k = 1; k <= v.gate; k++) begin
      pulse_in = (((k - 1) % v.period) == 0) && (((k - 1) / v.period) < v.n_edges);
      if (k == v.gate) check({nm, " valid early"}, out_valid, 0);
      tick();
    end
    pulse_in = 1'b0;
    check({nm, " valid"}, out_valid, 1);
    check({nm, " count"}, count, 64'(v.exp_count));
    check({nm, " sat"}, count_sat, 0);
    check({nm, " count4"}, count4, 64'(v.exp_count4));
    check({nm, " sat4"}, count_sat4, 64'(v.exp_sat4));
    check({nm, " idle"}, busy, 0);
    consume(nm);
  endtask

  initial begin
    //           gate per  n  cnt cnt4 sat4
    vecs[0] = '{10,  2, 99,  5,  5, 1'b0};  // one pulse every 2nd cycle
    vecs[1] = '{50,  2, 20, 20, 15, 1'b1};  // 20 edges saturate the 4-bit count
    vecs[2] = '{ 8,  2,  3,  3,  3, 1'b0};  // following window clears sat
    vecs[3] = '{ 1,  2,  1,  1,  1, 1'b0};  // shortest window with an edge
    vecs[4] = '{ 1,  2,  0,  0,  0, 1'b0};  // shortest window, no edge
    vecs[5] = '{31,  2, 16, 16, 15, 1'b1};  // wrap attempt on the final cycle
    vecs[6] = '{30,  2, 15, 15, 15, 1'b0};  // exactly full, no saturation
    vecs[7] = '{ 7,  3, 99,  3,  3, 1'b0};  // edges on first and last cycles

    reset = 1'b1; pulse_in = 1'b0; gate_len = '0; start = 1'b0;
    stop = 1'b0; cont = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst count", count, 0);
    check("rst valid", out_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst busy", busy, 0);
    check("rst sat", count_sat, 0);

    // Single windows from the table.
    for (int i = 0; i < 8; i++) run_vec(i);

    // Level already high when the window opens is not counted.
    for (int pass = 0; pass < 2; pass++) begin
      pulse_in = 1'b1;
      tick();                       // t0-2
      tick();                       // t0-1
      gate_len = GW'(20);
      start    = 1'b1;
      tick();                       // t0
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        pulse_in = (k <= 6) || (pass == 1 && k == 9);
        tick();
      end
      pulse_in = 1'b0;
      check($sformatf("prehigh%0d valid", pass), out_valid, 1);
      check($sformatf("prehigh%0d count", pass), count, 64'(pass));
      consume("prehigh");
    end

    // Continuous windows with nobody reading: overrun, newest value kept.
    cont = 1'b1; gate_len = GW'(8); out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      for (int k = 1; k <= 8; k++) begin
        pulse_in = ((k % 2) == 1) && (((k - 1) / 2) < w);
        tick();
      end
      pulse_in = 1'b0;
      check($sformatf("cont w%0d valid", w), out_valid, 1);
      check($sformatf("cont w%0d count", w), count, 64'(w));
      check($sformatf("cont w%0d overrun", w), overrun, (w >= 2) ? 1 : 0);
      check($sformatf("cont w%0d busy", w), busy, 1);
    end
    // Fourth window: transfer and new load coincide, cont dropped at the end.
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin
        out_ready = 1'b1;
        cont      = 1'b0;
      end
      tick();
    end
    check("cont w4 valid held", out_valid, 1);
    check("cont w4 count", count, 0);
    check("cont w4 idle", busy, 0);
    tick();
    out_ready = 1'b0;
    check("cont w4 taken", out_valid, 0);

    // Stop mid-window: no result, back to idle.
    gate_len = GW'(10); start = 1'b1;
    tick();                         // t0
    start = 1'b0;
    pulse_in = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    stop = 1'b1;
    tick();                         // t0+4 samples stop
    stop = 1'b0;
    pulse_in = 1'b0;
    check("stop busy", busy, 0);
    check("stop valid", out_valid, 0);
    for (int k = 0; k < 12; k++) tick();
    check("stop no result", out_valid, 0);
    // Zero gate length is ignored.
    gate_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("gate0 idle", busy, 0);
    // Stop on the final cycle wins over completion.
    gate_len = GW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop last busy", busy, 0);
    check("stop last valid", out_valid, 0);
    tick();
    check("stop last valid later", out_valid, 0);

    // Reset mid-window with a pending result and overrun set.
    cont = 1'b1; gate_len = GW'(4); start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pulse_in = (k == 1) || (k == 5);
      tick();
    end
    pulse_in = 1'b0;
    check("prerst count", count, 1);
    check("prerst overrun", overrun, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cont  = 1'b0;
    check("midrst count", count, 0);
    check("midrst valid", out_valid, 0);
    check("midrst overrun", overrun, 0);
    check("midrst busy", busy, 0);
    check("midrst sat4", count_sat4, 0);
    tick();
    check("midrst stays idle", busy, 0);
    run_vec(0);

    // Back-to-back single-cycle windows with the consumer always ready:
    // every load coincides with or follows a transfer, so no overrun.
    cont = 1'b1; gate_len = GW'(1); out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pulse_in = (k % 2) == 1;
      tick();
      check($sformatf("ready k%0d valid", k), out_valid, 1);
      check($sformatf("ready k%0d count", k), count, (k % 2) == 1 ? 1 : 0);
    end
    pulse_in = 1'b0;
    cont = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    check("ready overrun", overrun, 0);
    check("ready idle", busy, 0);
    check("ready drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
